// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - read-side controller that drains syn_fifo onto a valid/ready stream
module fifo_reader #(
    parameter int DATA_WIDTH  = 4,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_data,
    output logic                   fifo_rd_en,
    input  logic                   enable,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [COUNT_WIDTH-1:0] words_out,
    output logic                   busy
);

    logic [1:0]             occ_q, occ_d;
    logic                   inflight_q;
    logic [DATA_WIDTH-1:0]  head_q, head_d;
    logic [DATA_WIDTH-1:0]  tail_q, tail_d;
    logic [COUNT_WIDTH-1:0] words_q, words_d;

    logic       pop;
    logic [1:0] occ_after_pop;
    logic [1:0] committed;

    assign m_valid   = (occ_q != 2'd0);
    assign m_data    = head_q;
    assign words_out = words_q;
    assign busy      = (occ_q != 2'd0) | inflight_q;

    assign pop           = m_valid & m_ready;
    assign occ_after_pop = occ_q - {1'b0, pop};
    // Slots already spoken for after this cycle's pop; a read is only issued if one stays free.
    assign committed     = occ_after_pop + {1'b0, inflight_q};

    // rst gates the read directly so the FIFO is never read while the block is held in reset.
    assign fifo_rd_en = rst & enable & ~fifo_empty & (committed < 2'd2);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        occ_d   = committed;
        words_d = words_q + {{(COUNT_WIDTH-1){1'b0}}, pop};

        if (pop && (occ_q == 2'd2)) begin
            head_d = tail_q;
        end

        // Incoming word lands at head if the buffer drains empty this cycle, else behind it.
        if (inflight_q) begin
            if (occ_after_pop == 2'd0) begin
                head_d = fifo_data;
            end else begin
                tail_d = fifo_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            words_q    <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_rd_en;
            head_q     <= head_d;
            tail_q     <= tail_d;
            words_q    <= words_d;
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - directed bench for fifo_reader against a small syn_fifo model
module tb_fifo_reader;

    logic       clk;
    logic       rst;
    logic       fifo_empty;
    logic [3:0] fifo_data;
    logic       fifo_rd_en;
    logic       enable;
    logic [3:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] words_out;
    logic       busy;

    logic       fifo_rd_en_w;
    logic [3:0] m_data_w;
    logic       m_valid_w;
    logic [3:0] words_out_w;
    logic       busy_w;

    int errors = 0;
    int checks = 0;

    logic [3:0] mem [64];
    int wptr = 0;
    int rptr = 0;
    int cyc  = 0;

    bit         rdq[$];
    logic [3:0] rxq[$];
    int         popc[$];

    fifo_reader #(.DATA_WIDTH(4), .COUNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en), .enable(enable), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .words_out(words_out), .busy(busy)
    );

    fifo_reader #(.DATA_WIDTH(4), .COUNT_WIDTH(4)) u_wrap (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en_w), .enable(enable), .m_data(m_data_w), .m_valid(m_valid_w),
        .m_ready(m_ready), .words_out(words_out_w), .busy(busy_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty = (wptr == rptr);

    initial fifo_data = 4'h0;
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data <= mem[rptr & 63];
            rptr      <= rptr + 1;
        end
    end

    task automatic push(input logic [3:0] v);
        mem[wptr & 63] = v;
        wptr = wptr + 1;
    endtask

    task automatic step();
        #1;
        rdq.push_back(fifo_rd_en);
        if (m_valid && m_ready) begin
            rxq.push_back(m_data);
            popc.push_back(cyc);
        end
        @(posedge clk);
        @(negedge clk);
        cyc = cyc + 1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic int rd_sum();
        int s = 0;
        foreach (rdq[i]) s += int'(rdq[i]);
        return s;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        enable = 1'b0;
        m_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        wptr = rptr;
        rst = 1'b1;
        rdq.delete();
        rxq.delete();
        popc.delete();
        cyc = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        push(4'h6); push(4'h9); push(4'hB);
        enable = 1'b1;
        #1;
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en_held: got %0b want 0", fifo_rd_en); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %0b want 0", m_valid); end
        checks++; if (words_out !== 8'd0) begin errors++; $display("FAIL reset_words_out: got %0d want 0", words_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        rst = 1'b1;
        steps(4);
        checks++; if (m_valid !== 1'b1 || m_data !== 4'h6) begin errors++; $display("FAIL reset_prefill: got v=%0b d=%0h want v=1 d=6", m_valid, m_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_prefill_busy: got %0b want 1", busy); end
        rst = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0 || m_data !== 4'h0) begin errors++; $display("FAIL reset_async_out: got v=%0b d=%0h want v=0 d=0", m_valid, m_data); end
        checks++; if (busy !== 1'b0 || words_out !== 8'd0) begin errors++; $display("FAIL reset_async_busy_cnt: got busy=%0b cnt=%0d want 0 0", busy, words_out); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_async_rd_en: got %0b want 0", fifo_rd_en); end
        @(posedge clk);
        @(negedge clk);
        wptr = rptr;
        rst = 1'b1;
        m_ready = 1'b1;
        rdq.delete(); rxq.delete(); popc.delete(); cyc = 0;
        steps(4);
        checks++; if (rxq.size() !== 0) begin errors++; $display("FAIL reset_no_stale: got %0d pops want 0", rxq.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %0b want 0", busy); end
    endtask

    task automatic test_streaming();
        do_reset();
        for (int i = 0; i < 16; i++) push(4'(i));
        enable = 1'b1;
        m_ready = 1'b1;
        steps(22);
        for (int i = 0; i < 16; i++) begin
            checks++; if (rdq[i] !== 1'b1) begin errors++; $display("FAIL stream_rd_en[%0d]: got %0b want 1", i, rdq[i]); end
        end
        checks++; if (rdq[16] !== 1'b0) begin errors++; $display("FAIL stream_rd_en_stop: got %0b want 0", rdq[16]); end
        checks++; if (rxq.size() !== 16) begin errors++; $display("FAIL stream_count: got %0d want 16", rxq.size()); end
        for (int i = 0; i < 16; i++) begin
            if (i < rxq.size()) begin
                checks++; if (rxq[i] !== 4'(i) || popc[i] !== i + 2) begin
                    errors++; $display("FAIL stream_word[%0d]: got d=%0h cyc=%0d want d=%0h cyc=%0d", i, rxq[i], popc[i], i, i + 2);
                end
            end
        end
        checks++; if (words_out !== 8'd16) begin errors++; $display("FAIL stream_words_out: got %0d want 16", words_out); end
    endtask

    task automatic test_backpressure();
        logic [3:0] exp [4];
        int p;
        exp[0] = 4'h5; exp[1] = 4'hA; exp[2] = 4'h3; exp[3] = 4'hC;
        do_reset();
        for (int i = 0; i < 4; i++) push(exp[i]);
        enable = 1'b1;
        steps(6);
        checks++; if (rd_sum() !== 2) begin errors++; $display("FAIL bp_reads_held: got %0d want 2", rd_sum()); end
        checks++; if (m_valid !== 1'b1 || m_data !== 4'h5) begin errors++; $display("FAIL bp_head_held: got v=%0b d=%0h want v=1 d=5", m_valid, m_data); end
        m_ready = 1'b1;
        #1;
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL bp_resume_same_cycle: got %0b want 1", fifo_rd_en); end
        p = cyc;
        steps(8);
        checks++; if (rxq.size() !== 4) begin errors++; $display("FAIL bp_count: got %0d want 4", rxq.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < rxq.size()) begin
                checks++; if (rxq[i] !== exp[i] || popc[i] !== p + i) begin
                    errors++; $display("FAIL bp_word[%0d]: got d=%0h cyc=%0d want d=%0h cyc=%0d", i, rxq[i], popc[i], exp[i], p + i);
                end
            end
        end
        checks++; if (rd_sum() !== 4) begin errors++; $display("FAIL bp_total_reads: got %0d want 4", rd_sum()); end
    endtask

    task automatic test_empty_boundary();
        int e;
        do_reset();
        push(4'h7);
        enable = 1'b1;
        m_ready = 1'b1;
        steps(8);
        checks++; if (rd_sum() !== 1) begin errors++; $display("FAIL empty_single_read: got %0d want 1", rd_sum()); end
        checks++; if (rxq.size() !== 1 || rxq[0] !== 4'h7) begin errors++; $display("FAIL empty_first_word: got n=%0d want n=1 d=7", rxq.size()); end
        push(4'h9);
        #1;
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL empty_read_on_fall: got %0b want 1", fifo_rd_en); end
        e = cyc;
        steps(4);
        checks++; if (rxq.size() !== 2 || rxq[1] !== 4'h9 || popc[1] !== e + 2) begin
            errors++; $display("FAIL empty_late_word: got n=%0d want n=2 d=9 at cyc %0d", rxq.size(), e + 2);
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        push(4'h1); push(4'h2); push(4'h3);
        enable = 1'b1;
        m_ready = 1'b1;
        step();
        enable = 1'b0;
        steps(5);
        checks++; if (rd_sum() !== 1) begin errors++; $display("FAIL en_reads_stopped: got %0d want 1", rd_sum()); end
        checks++; if (rxq.size() !== 1 || rxq[0] !== 4'h1) begin errors++; $display("FAIL en_inflight_delivered: got n=%0d want n=1 d=1", rxq.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_idle_busy: got %0b want 0", busy); end
        enable = 1'b1;
        steps(8);
        checks++; if (rd_sum() !== 3) begin errors++; $display("FAIL en_resume_reads: got %0d want 3", rd_sum()); end
        checks++; if (rxq.size() !== 3 || rxq[1] !== 4'h2 || rxq[2] !== 4'h3) begin
            errors++; $display("FAIL en_resume_order: got n=%0d want 3 words 1,2,3", rxq.size());
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) push(4'((i * 3) & 15));
        enable = 1'b1;
        m_ready = 1'b1;
        steps(24);
        checks++; if (rxq.size() !== 17) begin errors++; $display("FAIL wrap_pops: got %0d want 17", rxq.size()); end
        checks++; if (words_out !== 8'd17) begin errors++; $display("FAIL wrap_words_out_8b: got %0d want 17", words_out); end
        checks++; if (words_out_w !== 4'd1) begin errors++; $display("FAIL wrap_words_out_4b: got %0d want 1", words_out_w); end
    endtask

    initial begin
        rst = 1'b0;
        enable = 1'b0;
        m_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_empty_boundary();
        test_enable_drop();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
